serial_hex_formatter: RTL

- Upstream feeder for `serial_transmitter`. Accepts one WIDTH-bit binary value per request over a valid/ready handshake.
- Converts the value to an ASCII hex line, e.g. "0xDEADBEEF\r\n", and emits it one byte at a time on the transmitter's tx_data / tx_data_available / tx_ready interface.
- Replaces fixed-string test traffic with live debug values (counters, status words) sent out the UART.

---
 rtl/serial_hex_formatter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_hex_formatter.sv
// Formats one WIDTH-bit value per request as an ASCII hex line ("0x...\r\n")
// and streams it byte-by-byte into a serial transmitter handshake.
module serial_hex_formatter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PREFIX    = 1,
  parameter int unsigned NEWLINE   = 1,
  parameter int unsigned LOWERCASE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_data_available,
  input  logic             tx_ready,
  output logic             busy
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((WIDTH == 0) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("serial_hex_formatter: WIDTH must be a nonzero multiple of 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    PFX0,
    PFX1,
    DIGIT,
    CR,
    LF
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] capture_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             armed;
  logic             armed_next;
  logic             take;
  logic [3:0]       nibble;
  logic [7:0]       hex_char;

  assign in_ready          = (state == IDLE);
  assign busy              = (state != IDLE);
  assign tx_data_available = (state != IDLE) && armed;
  assign take              = tx_data_available && tx_ready;

  // State, capture, digit counter and re-arm flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      capture <= '0;
      cnt     <= '0;
      armed   <= 1'b1;
    end else begin
      state   <= state_next;
      capture <= capture_next;
      cnt     <= cnt_next;
      armed   <= armed_next;
    end
  end

  always_comb begin
    state_next   = state;
    capture_next = capture;
    cnt_next     = cnt;
    armed_next   = armed;

    // Re-arm only after the transmitter has shown it went busy
    if (!tx_ready) begin
      armed_next = 1'b1;
    end else if (take) begin
      armed_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (in_valid) begin
          capture_next = in_data;
          cnt_next     = CW'(DIGITS - 1);
          state_next   = (PREFIX != 0) ? PFX0 : DIGIT;
        end
      end
      PFX0: begin
        if (take) state_next = PFX1;
      end
      PFX1: begin
        if (take) begin
          state_next = DIGIT;
          cnt_next   = CW'(DIGITS - 1);
        end
      end
      DIGIT: begin
        if (take) begin
          if (cnt == '0) begin
            state_next = (NEWLINE != 0) ? CR : IDLE;
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
      end
      CR: begin
        if (take) state_next = LF;
      end
      LF: begin
        if (take) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Most-significant digit first
  assign nibble = 4'(capture >> {cnt, 2'b00});

  always_comb begin
    if (nibble < 4'd10) begin
      hex_char = 8'h30 + 8'(nibble);
    end else begin
      hex_char = ((LOWERCASE != 0) ? 8'h57 : 8'h37) + 8'(nibble);
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      PFX0:    tx_data = 8'h30;
      PFX1:    tx_data = 8'h78;
      DIGIT:   tx_data = hex_char;
      CR:      tx_data = 8'h0D;
      LF:      tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

endmodule
